ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
- Instruction-fetch front end for the pipelined successor of the single-cycle core.
- Replaces the direct `inst_sram_addr = pc` / same-cycle `inst_sram_rdata` path with a request/response (sram-like) interface.
- Supports a parametrised number of outstanding requests, an in-order fetch buffer, branch/exception redirect with cancellation of in-flight responses, and a valid/ready handoff to decode.

Parameters:
- ADDR_W, 32, PC and instruction-address width.
- DEPTH, 4, fetch-buffer entries; power of two, ≥2. Bounds allocated entries plus responses still to be discarded.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_sram_req  out  1  fetch request valid
- inst_sram_addr  out  ADDR_W  fetch address (current pc)
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  response returned this cycle; responses arrive in request order
- inst_sram_rdata  in  32  response instruction
- flush  in  1  redirect from a later stage (branch/jirl/exception)
- flush_pc  in  ADDR_W  redirect target
- out_valid  out  1  decode entry valid
- out_ready  in  1  decode accepts entry
- out_pc  out  ADDR_W  pc of entry
- out_inst  out  32  instruction; 0 when out_adef=1
- out_adef  out  1  fetch-address-misaligned exception flag

Behaviour:
- Reset values:
  - pc=RESET_PC.
  - All buffer pointers and counts zero; discard_cnt=0.
  - Outputs: inst_sram_req=0, out_valid=0, out_pc=0, out_inst=0, out_adef=0.
- Credit rule: issue is allowed only when alloc_cnt + discard_cnt < DEPTH.
- Request:
  - inst_sram_req = credit & ~flush & (pc[1:0]==0).
  - inst_sram_addr = pc.
  - Once req=1, req and addr are held stable until addr_ok. Only flush may drop req.
- Accept (req & addr_ok):
  - Allocate the tail entry {pc, filled=0, adef=0}.
  - pc <= pc+4 (wraps modulo 2^ADDR_W).
  - Reflects in req/alloc_cnt next cycle.
- Misaligned pc (pc[1:0]!=0) with credit and no flush:
  - No bus request.
  - Allocate entry {pc, filled=1, adef=1, inst=0}.
  - pc is held; no further issue until flush.
- Response (data_ok):
  - If discard_cnt>0: decrement discard_cnt and drop the data.
  - Else: write rdata to the oldest unfilled entry and set filled=1.
  - data_ok with no outstanding request and discard_cnt==0 is a protocol error; ignore it and fire an assertion.
- Output:
  - out_valid = head entry allocated & filled & ~flush.
  - Pop on out_valid & out_ready.
  - Entries leave strictly in allocation order.
  - Data returned to the head entry is presentable the next cycle (1-cycle buffer latency). There is no combinational rdata→out path.
- Flush (highest priority):
  - pc <= flush_pc.
  - All entries are invalidated and pointers reset.
  - discard_cnt <= discard_cnt + (allocated-but-unfilled entries) − (1 if data_ok this cycle would have been discarded or filled).
  - No issue and no pop in the flush cycle.
- Simultaneous events:
  - Accept, fill and pop may occur in the same cycle; counts are updated net.
  - Buffer full plus pop plus accept in one cycle is legal; credit is evaluated on registered counts, so it is never exceeded.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; full and empty are distinguished by alloc_cnt.
- Reset mid-operation: all state clears, including discard_cnt. The memory side must be reset concurrently.

Decomposition:
- Shared package: RESET_PC default, instruction width (32), fetch-entry struct {pc, inst, filled, adef}.
- One sub-module: fetch_buf.
  - A DEPTH-entry circular buffer with alloc, fill and head pointers and a clear input.
  - ifu_fetch_queue holds the pc register, credit/discard counters and request logic.

Test Plan:
- Streaming: zero-wait memory (addr_ok=1, data_ok one cycle later), out_ready=1 → out_pc sequence 1c000000, 1c000004, 1c000008…; one entry per cycle after 3-cycle startup.
- Backpressure: out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, req stays 0 thereafter, no data lost. On release, pcs are in order with no gaps.
- Flush with 3 in flight: flush_pc=1c000100 → next 3 data_ok discarded. First out_pc is 1c000100, with its inst matching memory at 1c000100.
- Flush coincident with data_ok and out_ready → that data is not output; discard_cnt is net-correct; no stale pc ever appears after flush.
- Misaligned redirect: flush_pc=1c000102 → no bus request; out_valid with out_pc=1c000102, out_adef=1, out_inst=0. Fetching resumes on the next flush to 1c000200.
- Reset asserted with 2 outstanding requests → one cycle later req=0, out_valid=0; first request after reset is at 1c000000.

Source files
------------

// File: rtl/ifu_fetch_queue_pkg.sv
// ifu_fetch_queue_pkg: shared constants and fetch-buffer entry type
package ifu_fetch_queue_pkg;
  localparam int INST_W = 32;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h1c00_0000;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              filled;
    logic              adef;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_queue_fetch_buf.sv
// fetch_buf: in-order circular buffer of fetch entries with a separate fill pointer
module fetch_buf
  import ifu_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   alloc,
  input  logic [PC_W-1:0]        alloc_pc,
  input  logic                   alloc_adef,
  input  logic                   fill,
  input  logic [INST_W-1:0]      fill_inst,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t ent [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr, fill_ptr;
  assign head = ent[head_ptr];
  assign head_valid = count != '0 && head.filled;
  // Fault entries are born filled and are always youngest, so fill_ptr never has to skip one.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        ent[tail_ptr] <= '{pc: alloc_pc, inst: '0, filled: alloc_adef, adef: alloc_adef};
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (fill) begin
        ent[fill_ptr].inst <= fill_inst;
        ent[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(alloc) - CW'(pop);
    end
  end
endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: pipelined instruction fetch with credit-limited requests and redirect cancellation
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_sram_req,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_adef
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] alloc_cnt, discard_cnt, pend_cnt;
  logic halt, credit, aligned, accept, mis_alloc, drop, fill, pop, head_valid;
  fetch_entry_t head;
  // Credit counts responses still owed to cancelled entries so the buffer can never overflow.
  assign credit = ({1'b0, alloc_cnt} + {1'b0, discard_cnt}) < (CW+1)'(DEPTH);
  assign aligned = pc[1:0] == 2'b00;
  assign inst_sram_req = credit & ~flush & aligned & ~reset;
  assign inst_sram_addr = pc;
  assign accept = inst_sram_req & inst_sram_addr_ok;
  assign mis_alloc = credit & ~flush & ~aligned & ~halt & ~reset;
  assign drop = inst_sram_data_ok & (discard_cnt != '0);
  assign fill = inst_sram_data_ok & ~drop & (pend_cnt != '0) & ~flush;
  assign out_valid = head_valid & ~flush & ~reset;
  assign pop = out_valid & out_ready;
  assign out_pc = ADDR_W'(head.pc);
  assign out_inst = head.inst;
  assign out_adef = head.adef;
  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .clear(flush),
    .alloc(accept | mis_alloc),
    .alloc_pc(PC_W'(pc)),
    .alloc_adef(mis_alloc),
    .fill(fill),
    .fill_inst(inst_sram_rdata),
    .pop(pop),
    .head(head),
    .head_valid(head_valid),
    .count(alloc_cnt)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      discard_cnt <= '0;
      pend_cnt <= '0;
      halt <= 1'b0;
    end else if (flush) begin
      pc <= flush_pc;
      halt <= 1'b0;
      pend_cnt <= '0;
      discard_cnt <= discard_cnt + pend_cnt - CW'(inst_sram_data_ok & (discard_cnt != '0 | pend_cnt != '0));
    end else begin
      pc <= accept ? pc + ADDR_W'(4) : pc;
      halt <= halt | mis_alloc;
      pend_cnt <= pend_cnt + CW'(accept) - CW'(fill);
      discard_cnt <= discard_cnt - CW'(drop);
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset) assert (!(inst_sram_data_ok && discard_cnt == '0 && pend_cnt == '0))
      else $error("data_ok with no outstanding request");
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: directed scenario tests for ifu_fetch_queue against a zero-wait memory model
module tb_ifu_fetch_queue;
  logic clk = 1'b0, reset = 1'b1;
  logic inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_addr, inst_sram_rdata = '0;
  logic flush = 1'b0, out_valid, out_ready = 1'b0, out_adef;
  logic [31:0] flush_pc = '0, out_pc, out_inst;
  logic addr_ok = 1'b1, resp_en = 1'b1;
  int checks = 0, errors = 0, accept_cnt = 0;
  logic [31:0] mq [$];
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } rec_t;
  rec_t log_q [$];

  ifu_fetch_queue dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .flush(flush), .flush_pc(flush_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_adef(out_adef)
  );

  always #5 clk = ~clk;
  assign inst_sram_addr_ok = addr_ok;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  // Memory: answers each accepted request in the following cycle, in order, unless stalled.
  always @(posedge clk) begin
    logic acc, r;
    logic [31:0] a;
    acc = inst_sram_req & addr_ok;
    a = inst_sram_addr;
    r = reset;
    #1;
    if (r) begin
      mq.delete();
      inst_sram_data_ok = 1'b0;
    end else begin
      if (acc) begin
        mq.push_back(a);
        accept_cnt++;
      end
      if (resp_en && mq.size() > 0) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata = mem(mq.pop_front());
      end else inst_sram_data_ok = 1'b0;
    end
  end

  always @(posedge clk)
    if (!reset && out_valid && out_ready) log_q.push_back('{out_pc, out_inst, out_adef});

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; resp_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    log_q.delete();
    accept_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", inst_sram_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
    checks++; if (out_adef !== 1'b0) begin errors++; $display("FAIL reset_adef: got %b expected 0", out_adef); end
    @(negedge clk);
    release_reset();
    #1;
    checks++; if (inst_sram_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", inst_sram_req); end
    checks++; if (inst_sram_addr !== 32'h1c00_0000) begin errors++; $display("FAIL first_addr: got %h expected 1c000000", inst_sram_addr); end
  endtask

  task automatic test_streaming();
    do_reset();
    release_reset();
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (log_q.size() != 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].pc !== 32'h1c00_0000 + 32'(4*i) || log_q[i].inst !== mem(32'h1c00_0000 + 32'(4*i)) || log_q[i].adef !== 1'b0) begin
        errors++; $display("FAIL stream_entry[%0d]: got pc=%h inst=%h adef=%b expected pc=%h inst=%h", i, log_q[i].pc, log_q[i].inst, log_q[i].adef, 32'h1c00_0000 + 32'(4*i), mem(32'h1c00_0000 + 32'(4*i)));
      end
    end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0028) begin errors++; $display("FAIL stream_head: got valid=%b pc=%h expected 1 1c000028", out_valid, out_pc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    release_reset();
    repeat (10) @(negedge clk);
    #1;
    checks++; if (accept_cnt != 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", accept_cnt); end
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", inst_sram_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0000 || out_inst !== mem(32'h1c00_0000)) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h inst=%h expected 1 1c000000 %h", out_valid, out_pc, out_inst, mem(32'h1c00_0000)); end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (log_q.size() != 12) begin errors++; $display("FAIL bp_count: got %0d expected 12", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].pc !== 32'h1c00_0000 + 32'(4*i) || log_q[i].inst !== mem(32'h1c00_0000 + 32'(4*i))) begin
        errors++; $display("FAIL bp_entry[%0d]: got pc=%h inst=%h expected pc=%h", i, log_q[i].pc, log_q[i].inst, 32'h1c00_0000 + 32'(4*i));
      end
    end
  endtask

  task automatic test_flush_inflight();
    do_reset();
    release_reset();
    resp_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (accept_cnt != 3) begin errors++; $display("FAIL fi_inflight: got %0d expected 3", accept_cnt); end
    flush = 1'b1; flush_pc = 32'h1c00_0100;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL fi_req_in_flush: got %b expected 0", inst_sram_req); end
    @(negedge clk);
    flush = 1'b0; resp_en = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin errors++; $display("FAIL fi_redirect: got req=%b addr=%h expected 1 1c000100", inst_sram_req, inst_sram_addr); end
    repeat (15) @(negedge clk);
    #1;
    checks++; if (log_q.size() < 4) begin errors++; $display("FAIL fi_count: got %0d expected at least 4", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].pc !== 32'h1c00_0100 + 32'(4*i) || log_q[i].inst !== mem(32'h1c00_0100 + 32'(4*i))) begin
        errors++; $display("FAIL fi_entry[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i, log_q[i].pc, log_q[i].inst, 32'h1c00_0100 + 32'(4*i), mem(32'h1c00_0100 + 32'(4*i)));
      end
    end
  endtask

  task automatic test_flush_data_ok();
    do_reset();
    release_reset();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    flush = 1'b1; flush_pc = 32'h1c00_0200;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fd_valid_in_flush: got %b expected 0", out_valid); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL fd_pre_count: got %0d expected 4", log_q.size()); end
    repeat (12) @(negedge clk);
    #1;
    checks++; if (log_q.size() != 14) begin errors++; $display("FAIL fd_total: got %0d expected 14", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      logic [31:0] e;
      e = i < 4 ? 32'h1c00_0000 + 32'(4*i) : 32'h1c00_0200 + 32'(4*(i-4));
      checks++;
      if (log_q[i].pc !== e || log_q[i].inst !== mem(e)) begin
        errors++; $display("FAIL fd_entry[%0d]: got pc=%h inst=%h expected pc=%h inst=%h", i, log_q[i].pc, log_q[i].inst, e, mem(e));
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    release_reset();
    flush = 1'b1; flush_pc = 32'h1c00_0102;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL ma_req_flush: got %b expected 0", inst_sram_req); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL ma_req: got %b expected 0", inst_sram_req); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0102 || out_adef !== 1'b1 || out_inst !== 32'h0) begin
      errors++; $display("FAIL ma_entry: got valid=%b pc=%h adef=%b inst=%h expected 1 1c000102 1 0", out_valid, out_pc, out_adef, out_inst);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || inst_sram_req !== 1'b0 || accept_cnt != 0) begin errors++; $display("FAIL ma_halt: got valid=%b req=%b accepts=%0d expected 0 0 0", out_valid, inst_sram_req, accept_cnt); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL ma_pops: got %0d expected 1", log_q.size()); end
    flush = 1'b1; flush_pc = 32'h1c00_0200;
    @(negedge clk);
    flush = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (log_q.size() != 7) begin errors++; $display("FAIL ma_resume_count: got %0d expected 7", log_q.size()); end
    for (int i = 1; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].pc !== 32'h1c00_0200 + 32'(4*(i-1)) || log_q[i].inst !== mem(32'h1c00_0200 + 32'(4*(i-1))) || log_q[i].adef !== 1'b0) begin
        errors++; $display("FAIL ma_resume[%0d]: got pc=%h inst=%h adef=%b expected pc=%h", i, log_q[i].pc, log_q[i].inst, log_q[i].adef, 32'h1c00_0200 + 32'(4*(i-1)));
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    release_reset();
    resp_en = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (accept_cnt != 2) begin errors++; $display("FAIL rm_inflight: got %0d expected 2", accept_cnt); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (inst_sram_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_cleared: got req=%b valid=%b expected 0 0", inst_sram_req, out_valid); end
    release_reset();
    resp_en = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin errors++; $display("FAIL rm_restart: got req=%b addr=%h expected 1 1c000000", inst_sram_req, inst_sram_addr); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL rm_count: got %0d expected 4", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].pc !== 32'h1c00_0000 + 32'(4*i) || log_q[i].inst !== mem(32'h1c00_0000 + 32'(4*i))) begin
        errors++; $display("FAIL rm_entry[%0d]: got pc=%h inst=%h expected pc=%h", i, log_q[i].pc, log_q[i].inst, 32'h1c00_0000 + 32'(4*i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_inflight();
    test_flush_data_ok();
    test_misaligned();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
